// File: rtl/stack_machine_pkg.sv
// Shared opcode, error-code and FSM-state encodings for the stack_machine core.
package stack_machine_pkg;

   localparam logic [3:0] OP_PUSHC = 4'h0;
   localparam logic [3:0] OP_PUSH  = 4'h1;
   localparam logic [3:0] OP_POP   = 4'h2;
   localparam logic [3:0] OP_JUMP  = 4'h3;
   localparam logic [3:0] OP_JZ    = 4'h4;
   localparam logic [3:0] OP_JS    = 4'h5;
   localparam logic [3:0] OP_ADD   = 4'h6;
   localparam logic [3:0] OP_SUB   = 4'h7;
   localparam logic [3:0] OP_DUP   = 4'h8;
   localparam logic [3:0] OP_SWAP  = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_SOVF    = 3'd1;
   localparam logic [2:0] ERR_SUNF    = 3'd2;
   localparam logic [2:0] ERR_ARITH   = 3'd3;
   localparam logic [2:0] ERR_ILLEGAL = 3'd4;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_MEM   = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

endpackage

// File: rtl/stack_machine_if.sv
// Instruction-fetch and data-memory bus of the stack_machine core.
interface stack_machine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0]   imem_addr;
   logic [3+ADDR_W:0]   imem_data;
   logic                dmem_req;
   logic                dmem_we;
   logic [ADDR_W-1:0]   dmem_addr;
   logic [DATA_W-1:0]   dmem_wdata;
   logic [DATA_W-1:0]   dmem_rdata;
   logic                dmem_ack;

   modport master (
      output imem_addr,
      input  imem_data,
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_rdata,
      input  dmem_ack
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_rdata,
      output dmem_ack
   );
endinterface

// File: rtl/stack_file.sv
// Register-array stack with occupancy count; the core guarantees ops are legal.
module stack_file #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 8,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              replace2,
   input  logic              swap,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] top,
   output logic [DATA_W-1:0] second,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  top_idx;
   logic [IDX_W-1:0]  sec_idx;
   logic [IDX_W-1:0]  push_idx;

   assign top_idx  = IDX_W'(cnt - CNT_W'(1));
   assign sec_idx  = IDX_W'(cnt - CNT_W'(2));
   assign push_idx = IDX_W'(cnt);

   assign top    = mem[top_idx];
   assign second = mem[sec_idx];
   assign count  = cnt;
   assign full   = (cnt == CNT_W'(DEPTH));
   assign empty  = (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (push) begin
         cnt <= cnt + CNT_W'(1);
      end else if (pop || replace2) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Contents are not reset; only the count defines what is valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push) begin
            mem[push_idx] <= wdata;
         end else if (replace2) begin
            mem[sec_idx] <= wdata;
         end else if (swap) begin
            mem[top_idx] <= mem[sec_idx];
            mem[sec_idx] <= mem[top_idx];
         end
      end
   end

endmodule

// File: rtl/stack_machine.sv
// Stack processor core: registered fetch, single-cycle execute, req/ack data access.
//  state   | meaning
//  FETCH   | latch instruction at PC into IR
//  EXEC    | check errors, commit non-memory ops or start a memory access
//  MEM     | hold data request until ack, then push/pop and advance PC
//  HALT    | stopped (HALT opcode or error); only reset leaves
module stack_machine
   import stack_machine_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int ADDR_W = 8,
   parameter  int DEPTH  = 8,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   stack_machine_if.master   bus,
   output logic              halted,
   output logic              error,
   output logic [2:0]        err_code,
   output logic [ADDR_W-1:0] pc,
   output logic [CNT_W-1:0]  depth_cnt
);

   logic [1:0]          state;
   logic [1:0]          nxt_state;
   logic [3+ADDR_W:0]   ir;
   logic [ADDR_W-1:0]   nxt_pc;
   logic                z_flag;
   logic                s_flag;
   logic                req;
   logic                we;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;

   logic [3:0]          op;
   logic [ADDR_W-1:0]   operand;
   logic [ADDR_W-1:0]   pc_inc;
   logic [DATA_W-1:0]   opd_data;
   logic [ADDR_W-1:0]   top_addr;
   logic [ADDR_W+DATA_W-1:0] opd_wide;
   logic [ADDR_W+DATA_W-1:0] top_wide;

   logic [DATA_W-1:0]   top;
   logic [DATA_W-1:0]   second;
   logic                full;
   logic                empty;
   logic [DATA_W-1:0]   sum;
   logic [DATA_W-1:0]   diff;
   logic [DATA_W-1:0]   arith_res;
   logic                arith_ovf;
   logic                two_ok;

   logic                stk_push;
   logic                stk_pop;
   logic                stk_rep;
   logic                stk_swap;
   logic [DATA_W-1:0]   stk_wdata;
   logic                err_hit;
   logic [2:0]          err_val;
   logic                mem_go;
   logic                flag_upd;
   logic                taken;

   stack_file #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_stack (
      .clk      (clk),
      .reset    (reset),
      .push     (stk_push),
      .pop      (stk_pop),
      .replace2 (stk_rep),
      .swap     (stk_swap),
      .wdata    (stk_wdata),
      .top      (top),
      .second   (second),
      .count    (depth_cnt),
      .full     (full),
      .empty    (empty)
   );

   assign op       = ir[3+ADDR_W:ADDR_W];
   assign operand  = ir[ADDR_W-1:0];
   assign pc_inc   = pc + ADDR_W'(1);

   // Zero-extend or truncate between the address and data widths.
   assign opd_wide = {{DATA_W{1'b0}}, operand};
   assign top_wide = {{ADDR_W{1'b0}}, top};
   assign opd_data = opd_wide[DATA_W-1:0];
   assign top_addr = top_wide[ADDR_W-1:0];

   assign sum       = second + top;
   assign diff      = second - top;
   assign arith_res = (op == OP_SUB) ? diff : sum;
   assign arith_ovf = (op == OP_SUB)
                    ? ((second[DATA_W-1] != top[DATA_W-1]) && (diff[DATA_W-1] != second[DATA_W-1]))
                    : ((second[DATA_W-1] == top[DATA_W-1]) && (sum[DATA_W-1] != top[DATA_W-1]));
   assign two_ok    = (depth_cnt >= CNT_W'(2));
   assign taken     = (op == OP_JZ) ? z_flag : s_flag;

   always_comb begin
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_rep   = 1'b0;
      stk_swap  = 1'b0;
      stk_wdata = top;
      nxt_state = state;
      nxt_pc    = pc;
      err_hit   = 1'b0;
      err_val   = ERR_NONE;
      mem_go    = 1'b0;
      flag_upd  = 1'b0;
      case (state)
         S_FETCH: nxt_state = S_EXEC;
         S_EXEC: begin
            nxt_state = S_FETCH;
            case (op)
               OP_PUSHC: begin
                  if (full) begin
                     err_hit = 1'b1; err_val = ERR_SOVF;
                  end else begin
                     stk_push = 1'b1; stk_wdata = opd_data; nxt_pc = pc_inc;
                  end
               end
               OP_PUSH: begin
                  if (full) begin
                     err_hit = 1'b1; err_val = ERR_SOVF;
                  end else begin
                     mem_go = 1'b1; nxt_state = S_MEM;
                  end
               end
               OP_POP: begin
                  if (empty) begin
                     err_hit = 1'b1; err_val = ERR_SUNF;
                  end else begin
                     mem_go = 1'b1; nxt_state = S_MEM;
                  end
               end
               OP_JUMP: begin
                  if (empty) begin
                     err_hit = 1'b1; err_val = ERR_SUNF;
                  end else begin
                     stk_pop = 1'b1; nxt_pc = top_addr;
                  end
               end
               OP_JZ, OP_JS: begin
                  if (!taken) begin
                     nxt_pc = pc_inc;
                  end else if (empty) begin
                     err_hit = 1'b1; err_val = ERR_SUNF;
                  end else begin
                     stk_pop = 1'b1; nxt_pc = top_addr;
                  end
               end
               OP_ADD, OP_SUB: begin
                  if (!two_ok) begin
                     err_hit = 1'b1; err_val = ERR_SUNF;
                  end else if (arith_ovf) begin
                     err_hit = 1'b1; err_val = ERR_ARITH;
                  end else begin
                     stk_rep = 1'b1; stk_wdata = arith_res; flag_upd = 1'b1; nxt_pc = pc_inc;
                  end
               end
               OP_DUP: begin
                  if (full) begin
                     err_hit = 1'b1; err_val = ERR_SOVF;
                  end else begin
                     stk_push = 1'b1; stk_wdata = top; nxt_pc = pc_inc;
                  end
               end
               OP_SWAP: begin
                  if (!two_ok) begin
                     err_hit = 1'b1; err_val = ERR_SUNF;
                  end else begin
                     stk_swap = 1'b1; nxt_pc = pc_inc;
                  end
               end
               OP_HALT: nxt_state = S_HALT;
               default: begin
                  err_hit = 1'b1; err_val = ERR_ILLEGAL;
               end
            endcase
            if (err_hit) nxt_state = S_HALT;
         end
         S_MEM: begin
            if (bus.dmem_ack) begin
               if (we) begin
                  stk_pop = 1'b1;
               end else begin
                  stk_push  = 1'b1;
                  stk_wdata = bus.dmem_rdata;
               end
               nxt_pc    = pc_inc;
               nxt_state = S_FETCH;
            end
         end
         default: nxt_state = S_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= '0;
         ir       <= '0;
         z_flag   <= 1'b0;
         s_flag   <= 1'b0;
         error    <= 1'b0;
         err_code <= ERR_NONE;
         req      <= 1'b0;
         we       <= 1'b0;
         addr     <= '0;
         wdata    <= '0;
      end else begin
         state <= nxt_state;
         pc    <= nxt_pc;
         if (state == S_FETCH) ir <= bus.imem_data;
         if (flag_upd) begin
            z_flag <= (arith_res == '0);
            s_flag <= arith_res[DATA_W-1];
         end
         if (err_hit) begin
            error    <= 1'b1;
            err_code <= err_val;
         end
         // Request fields are captured once in EXEC and held through MEM.
         if (mem_go) begin
            req   <= 1'b1;
            we    <= (op == OP_POP);
            addr  <= operand;
            wdata <= top;
         end else if ((state == S_MEM) && bus.dmem_ack) begin
            req <= 1'b0;
            we  <= 1'b0;
         end
      end
   end

   assign halted         = (state == S_HALT);
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = req;
   assign bus.dmem_we    = we;
   assign bus.dmem_addr  = addr;
   assign bus.dmem_wdata = wdata;

endmodule

// File: tb/tb_stack_machine.sv
// Program-level bench: an ISA interpreter predicts memory traffic and final state per program.
module tb_stack_machine;
   import stack_machine_pkg::*;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic halted, error;
   logic [2:0] err_code;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0] depth_cnt;

   stack_machine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   stack_machine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .halted    (halted),
      .error     (error),
      .err_code  (err_code),
      .pc        (pc),
      .depth_cnt (depth_cnt)
   );

   always #5 clk = ~clk;

   logic [11:0] imem [256];
   logic [7:0]  dmem [256];
   assign bus.imem_data = imem[bus.imem_addr];

   typedef struct { bit we; int addr; int wdata; } txn_t;
   typedef struct { int ec; int depth; int top; int second; bit z; bit s; int pc; int cycles; int ntxn; } fin_t;

   txn_t exp_txn[$];
   fin_t exp_fin[$];
   int   delay_q[$];
   int   checks = 0;
   int   errors = 0;
   int   fixed_delay = -1;
   bit   m_bad;
   int   cyc = 0;
   int   halt_cyc = 0;
   int   txn_cnt = 0;
   bit   run_active = 0;
   bit   run_done = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int sx(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   function automatic int pick_delay();
      int d;
      d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      delay_q.push_back(d);
      return d;
   endfunction

   // ISA-level interpreter over the current imem/dmem contents.
   task automatic run_model();
      int stk[$];
      int mm[256];
      int mpc, cy, nt, ec, ins, op, opd, npc, d, a, b, r, t;
      bit z, s, done;
      txn_t tx;
      fin_t f;
      exp_txn.delete(); exp_fin.delete(); delay_q.delete();
      for (int i = 0; i < 256; i++) mm[i] = int'(dmem[i]);
      m_bad = 0; mpc = 0; cy = 0; nt = 0; ec = 0; z = 0; s = 0; done = 0;
      for (int step = 0; step < 500 && !done; step++) begin
         ins = int'(imem[mpc]); op = ins >> 8; opd = ins & 255; npc = (mpc + 1) % 256;
         cy += 2;
         case (op)
            0: if (stk.size() == DEPTH) ec = 1; else stk.push_back(opd);
            1: if (stk.size() == DEPTH) ec = 1;
               else begin
                  d = pick_delay(); cy += 1 + d; nt++;
                  stk.push_back(mm[opd]);
                  tx.we = 0; tx.addr = opd; tx.wdata = 0; exp_txn.push_back(tx);
               end
            2: if (stk.size() == 0) ec = 2;
               else begin
                  d = pick_delay(); cy += 1 + d; nt++;
                  t = stk.pop_back(); mm[opd] = t;
                  tx.we = 1; tx.addr = opd; tx.wdata = t; exp_txn.push_back(tx);
               end
            3: if (stk.size() == 0) ec = 2; else npc = stk.pop_back();
            4, 5: if ((op == 4) ? z : s) begin
                     if (stk.size() == 0) ec = 2; else npc = stk.pop_back();
                  end
            6, 7: if (stk.size() < 2) ec = 2;
                  else begin
                     a = sx(stk[stk.size()-2]); b = sx(stk[stk.size()-1]);
                     r = (op == 6) ? a + b : a - b;
                     if (r > 127 || r < -128) ec = 3;
                     else begin
                        t = stk.pop_back();
                        stk[stk.size()-1] = r & 255;
                        z = (r == 0); s = (r < 0);
                     end
                  end
            8: if (stk.size() == DEPTH) ec = 1;
               else if (stk.size() == 0) m_bad = 1;
               else stk.push_back(stk[stk.size()-1]);
            9: if (stk.size() < 2) ec = 2;
               else begin
                  t = stk[stk.size()-1];
                  stk[stk.size()-1] = stk[stk.size()-2];
                  stk[stk.size()-2] = t;
               end
            15: done = 1;
            default: ec = 4;
         endcase
         if (ec != 0 || m_bad) done = 1;
         if (!done) mpc = npc;
      end
      if (!done) m_bad = 1;
      f.ec = ec; f.depth = stk.size(); f.z = z; f.s = s; f.pc = mpc; f.cycles = cy; f.ntxn = nt;
      f.top = (stk.size() > 0) ? stk[stk.size()-1] : 0;
      f.second = (stk.size() > 1) ? stk[stk.size()-2] : 0;
      exp_fin.push_back(f);
   endtask

   initial forever begin
      @(posedge clk);
      cyc = reset ? 0 : cyc + 1;
   end

   // Memory responder and transaction monitor.
   initial begin
      int wait_left, hi_cnt, exp_hi;
      bit busy, we_s;
      int addr_s, wd_s;
      txn_t t;
      busy = 0; wait_left = 0; hi_cnt = 0; exp_hi = 0; we_s = 0; addr_s = 0; wd_s = 0;
      bus.dmem_ack = 1'b0;
      bus.dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.dmem_ack) begin
            bus.dmem_ack = 1'b0;
         end else if (bus.dmem_req && !reset) begin
            if (!busy) begin
               busy = 1; hi_cnt = 0;
               if (delay_q.size() > 0) wait_left = delay_q.pop_front(); else wait_left = 0;
               exp_hi = wait_left + 1;
               we_s = bus.dmem_we; addr_s = int'(bus.dmem_addr); wd_s = int'(bus.dmem_wdata);
            end
            hi_cnt++;
            check("req_hold", {bus.dmem_we, bus.dmem_addr, bus.dmem_wdata}, {we_s, addr_s[7:0], wd_s[7:0]});
            if (wait_left == 0) begin
               bus.dmem_rdata = dmem[bus.dmem_addr];
               if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
               bus.dmem_ack = 1'b1;
               busy = 0;
               txn_cnt++;
               check("req_cycles", hi_cnt, exp_hi);
               if (exp_txn.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_req: got request addr=0x%0h we=%0d expected none", bus.dmem_addr, bus.dmem_we);
               end else begin
                  t = exp_txn.pop_front();
                  check("txn_we", int'(bus.dmem_we), int'(t.we));
                  check("txn_addr", int'(bus.dmem_addr), t.addr);
                  if (t.we) check("txn_wdata", int'(bus.dmem_wdata), t.wdata);
               end
            end else begin
               wait_left--;
            end
         end else begin
            busy = 0;
         end
      end
   end

   // Final-state monitor: fires when the core reaches HALT.
   initial begin
      fin_t f;
      forever begin
         @(negedge clk);
         if (run_active && !run_done && !reset && halted) begin
            run_done = 1;
            halt_cyc = cyc;
            if (exp_fin.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_halt: got halted=1 expected no halt");
            end else begin
               f = exp_fin.pop_front();
               check("error", int'(error), int'(f.ec != 0));
               check("err_code", int'(err_code), f.ec);
               check("depth_cnt", int'(depth_cnt), f.depth);
               check("pc", int'(pc), f.pc);
               check("z_flag", int'(dut.z_flag), int'(f.z));
               check("s_flag", int'(dut.s_flag), int'(f.s));
               check("cycles", halt_cyc, f.cycles);
               check("txn_count", txn_cnt, f.ntxn);
               if (f.depth >= 1) check("top", int'(dut.u_stack.top), f.top);
               if (f.depth >= 2) check("second", int'(dut.u_stack.second), f.second);
            end
         end
      end
   end

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) imem[i] = 12'hF00;
   endtask

   task automatic start_run(input string name);
      int n;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      txn_cnt = 0; run_done = 0; run_active = 1;
      reset = 1'b0;
      n = 0;
      while (!run_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!run_done) begin
         checks++; errors++;
         $display("FAIL timeout_%s: got no halt after %0d cycles expected halt", name, n);
      end
      @(negedge clk);
      check("halted_hold", int'(halted), 1);
      run_active = 0;
   endtask

   task automatic directed(input string name, input logic [11:0] p [16], input int len, input int dly);
      clear_prog();
      for (int i = 0; i < len; i++) imem[i] = p[i];
      fixed_delay = dly;
      run_model();
      start_run(name);
   endtask

   initial begin
      logic [11:0] p [16];
      int len, r;
      for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
      clear_prog();
      repeat (3) @(negedge clk);
      check("rst_halted", int'(halted), 0);
      check("rst_error", int'(error), 0);
      check("rst_err_code", int'(err_code), 0);
      check("rst_pc", int'(pc), 0);
      check("rst_depth", int'(depth_cnt), 0);
      check("rst_req", int'(bus.dmem_req), 0);
      check("rst_we", int'(bus.dmem_we), 0);

      p[0] = 12'h005; p[1] = 12'h003; p[2] = 12'h700; p[3] = 12'hF00;
      directed("sub", p, 4, -1);
      check("sub_halt_cycle", halt_cyc, 8);
      check("sub_top", int'(dut.u_stack.top), 2);

      p[0] = 12'h064; p[1] = 12'h064; p[2] = 12'h600; p[3] = 12'hF00;
      directed("add_ovf", p, 4, -1);
      check("add_ovf_code", int'(err_code), 3);

      for (int i = 0; i < 9; i++) p[i] = 12'h001;
      p[9] = 12'hF00;
      directed("stack_ovf", p, 10, -1);
      check("stack_ovf_depth", int'(depth_cnt), 8);

      p[0] = 12'h210; p[1] = 12'hF00;
      directed("pop_empty", p, 2, -1);
      check("pop_empty_code", int'(err_code), 2);

      dmem[8'h30] = 8'h85;
      p[0] = 12'h007; p[1] = 12'h220; p[2] = 12'h130; p[3] = 12'hF00;
      directed("mem_wait", p, 4, 3);
      check("mem_wait_top", int'(dut.u_stack.top), 8'h85);

      p[0] = 12'h003; p[1] = 12'h001; p[2] = 12'h700; p[3] = 12'h008;
      p[4] = 12'h400; p[5] = 12'h2F0; p[6] = 12'h001; p[7] = 12'h300; p[8] = 12'hF00;
      directed("loop", p, 9, -1);
      check("loop_depth", int'(depth_cnt), 1);
      check("loop_top", int'(dut.u_stack.top), 0);

      // Reset while a read is waiting for ack.
      clear_prog();
      imem[0] = 12'h009; imem[1] = 12'h110;
      exp_txn.delete(); exp_fin.delete(); delay_q.delete();
      delay_q.push_back(50);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_req_before", int'(bus.dmem_req), 1);
      check("mid_depth_before", int'(depth_cnt), 1);
      check("mid_pc_before", int'(pc), 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_req_after", int'(bus.dmem_req), 0);
      check("mid_pc_after", int'(pc), 0);
      check("mid_depth_after", int'(depth_cnt), 0);
      check("mid_state_after", int'(dut.state), int'(S_FETCH));
      delay_q.delete();

      p[0] = 12'h001; p[1] = 12'hB00; p[2] = 12'hF00;
      directed("illegal", p, 3, -1);
      check("illegal_code", int'(err_code), 4);

      fixed_delay = -1;
      for (int k = 0; k < 40; k++) begin
         do begin
            clear_prog();
            len = $urandom_range(4, 20);
            for (int i = 0; i < len; i++) begin
               r = $urandom_range(0, 39);
               if (r < 12)      imem[i] = {4'h0, 8'($urandom)};
               else if (r < 16) imem[i] = {4'h1, 8'($urandom)};
               else if (r < 20) imem[i] = {4'h2, 8'($urandom)};
               else if (r < 26) imem[i] = 12'h600;
               else if (r < 32) imem[i] = 12'h700;
               else if (r < 35) imem[i] = 12'h800;
               else if (r < 38) imem[i] = 12'h900;
               else if (r < 39) imem[i] = {4'($urandom_range(10, 14)), 8'h00};
               else             imem[i] = 12'hF00;
            end
            run_model();
         end while (m_bad);
         start_run("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
